eca_engine: RTL and testbench
=============================

Name: eca_engine

Overview:
- Parametrised one-dimensional elementary cellular-automaton engine. Its combinational core generalises the fixed 3-input truth-table logic blocks to WIDTH cells under a runtime-programmable 8-bit rule.
- Accepts a configuration (rule, seed, step count, boundary mode) and iterates one generation per cycle.
- Streams each generation out over a valid/ready interface with backpressure.
- Sits between the stimulus/config front end and the logic-characterisation capture path.

Parameters:
- WIDTH, 16, number of cells (>=3).
- STEP_W, 16, width of the step-count and generation-index fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  engine can accept a configuration (high only in IDLE).
- cfg_rule  in  8  rule table.
- cfg_seed  in  WIDTH  generation-0 state.
- cfg_steps  in  STEP_W  number of generations to compute after the seed.
- cfg_wrap  in  1  1 = toroidal boundary, 0 = fixed boundary.
- cfg_edge  in  1  value of out-of-range neighbours when cfg_wrap=0.
- abort  in  1  synchronous abort of the current run.
- out_valid  out  1  out_data/out_gen hold a generation.
- out_ready  in  1  consumer accepts the generation.
- out_data  out  WIDTH  current generation state.
- out_gen  out  STEP_W  generation index, 0 = seed.
- busy  out  1  high in EMIT.
- done  out  1  one-cycle pulse after the final generation is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst.
- Reset values: state IDLE; out_valid=0, busy=0, done=0, out_data=0, out_gen=0. cfg_ready=1 in the cycle after rst deasserts.
- rst overrides everything, including mid-run and when asserted together with cfg_valid.
- Rule encoding: for cell i with pattern p={left,centre,right}, next = cfg_rule[7-p]. Rule bit 7 is the response to pattern 000 and bit 0 the response to 111. So 8'h2D gives 000->0, 001->0, 010->1, 011->0, 100->1, 101->1, 110->0, 111->1.
- Neighbours: left of cell i is cell i+1 (MSB side); right is cell i-1.
  - cfg_wrap=1: left of cell WIDTH-1 is cell 0; right of cell 0 is cell WIDTH-1.
  - cfg_wrap=0: both out-of-range neighbours equal the latched cfg_edge.
- FSM state IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch rule, wrap and edge; state<=seed; remaining<=cfg_steps; gen<=0; go to EMIT.
- FSM state EMIT:
  - out_valid=1, busy=1, cfg_ready=0.
  - out_valid asserts the cycle after the cfg handshake.
  - Handshake with remaining==0: return to IDLE and pulse done for one cycle, coincident with out_valid falling.
  - Handshake with remaining!=0: state<=next(state), remaining<=remaining-1, gen<=gen+1, stay in EMIT.
  - With out_ready held high, throughput is one generation per cycle.
  - With out_ready low, out_data and out_gen are held stable and out_valid stays high (no drop, no advance).
- Run length: cfg_steps=0 emits only the seed (one transfer). cfg_steps=N emits N+1 transfers, with out_gen 0..N.
- abort in EMIT: next cycle IDLE, out_valid=0, no done. abort takes priority over a same-cycle handshake. abort in IDLE is ignored, and a same-cycle cfg_valid is still accepted.
- cfg_valid while not in IDLE is ignored (cfg_ready=0). Latched config does not change mid-run.
- out_data and out_gen keep their last values in IDLE. Consumers qualify them with out_valid.
- out_gen counts modulo 2^STEP_W; it cannot wrap within a run because cfg_steps < 2^STEP_W.

Decomposition:
- eca_pkg holds:
  - state enum (IDLE, EMIT);
  - RULE_W=8;
  - the pattern-index function {l,c,r} -> 7-p.
- Sub-module eca_cell:
  - combinational; inputs l, c, r, rule[7:0]; output next;
  - instantiated WIDTH times via generate, with boundary muxing in the parent.

Test Plan:
1. WIDTH=8, rule 8'h5A (left XOR right), wrap=1, seed 8'h10, steps=2, out_ready=1 -> out_data 8'h10, 8'h28, 8'h44 on consecutive cycles; out_gen 0, 1, 2; done pulses once; cfg_ready returns high.
2. Rule 8'h5A, seed 8'h80, steps=1:
   - wrap=1 -> gen1 = 8'h41;
   - wrap=0, edge=0 -> 8'h40;
   - wrap=0, edge=1 -> 8'hC1.
3. Rule 8'h2D, wrap=0, edge=0, steps=1: seed 8'hFF -> gen1 8'h7E; seed 8'h00 -> gen1 8'h00.
4. Backpressure: steps=3 with out_ready low for 3 cycles at gen1 -> out_valid, out_data and out_gen stay constant; the total is still exactly 4 transfers; steps=0 -> a single transfer then done.
5. Abort at gen2 of steps=10 -> out_valid=0 next cycle, no done pulse, cfg_ready=1. An immediate new cfg is accepted and starts at out_gen=0.
6. rst asserted mid-run with cfg_valid high -> all outputs at their reset values next cycle and no config latched. After rst deasserts, cfg_ready=1.

Source files
------------

// File: rtl/eca_pkg.sv
// rtl/eca_pkg.sv - shared types, constants and rule-lookup helper for the ECA engine
package eca_pkg;

    localparam int RULE_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } eca_state_t;

    // Rule bit 7 answers pattern 000 and bit 0 answers 111, so the
    // neighbourhood value is mirrored to get the bit position.
    function automatic logic [2:0] rule_idx(input logic l, input logic c, input logic r);
        return 3'd7 - {l, c, r};
    endfunction

endpackage

// File: rtl/eca_cell.sv
// rtl/eca_cell.sv - one cellular-automaton cell: rule lookup on {left, centre, right}
// Ports: l/c/r neighbourhood bits, rule table in, next cell value out.
module eca_cell
    import eca_pkg::*;
(
    input  logic              l,
    input  logic              c,
    input  logic              r,
    input  logic [RULE_W-1:0] rule,
    output logic              next
);

    assign next = rule[rule_idx(l, c, r)];

endmodule

// File: rtl/eca_engine.sv
// rtl/eca_engine.sv - elementary cellular-automaton engine streaming one generation per cycle
// Ports: clk/rst (sync, active-high); cfg_* configuration handshake (rule, seed,
// steps, wrap, edge); abort; out_valid/out_ready/out_data/out_gen generation
// stream; busy while emitting; done pulses after the final generation is taken.
module eca_engine
    import eca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [RULE_W-1:0] cfg_rule,
    input  logic [WIDTH-1:0]  cfg_seed,
    input  logic [STEP_W-1:0] cfg_steps,
    input  logic              cfg_wrap,
    input  logic              cfg_edge,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [STEP_W-1:0] out_gen,
    output logic              busy,
    output logic              done
);

    eca_state_t        r_state;
    logic [RULE_W-1:0] r_rule;
    logic              r_wrap;
    logic              r_edge;
    logic [WIDTH-1:0]  r_data;
    logic [STEP_W-1:0] r_remaining;
    logic [STEP_W-1:0] r_gen;
    logic              r_done;

    logic [WIDTH-1:0]  w_left;
    logic [WIDTH-1:0]  w_right;
    logic [WIDTH-1:0]  w_next;

    // Left neighbour sits on the MSB side, right neighbour on the LSB side.
    // The two end cells take either the opposite end (wrap) or the edge value.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            if (gi == WIDTH - 1) begin : g_left_end
                assign w_left[gi] = r_wrap ? r_data[0] : r_edge;
            end else begin : g_left_mid
                assign w_left[gi] = r_data[gi+1];
            end

            if (gi == 0) begin : g_right_end
                assign w_right[gi] = r_wrap ? r_data[WIDTH-1] : r_edge;
            end else begin : g_right_mid
                assign w_right[gi] = r_data[gi-1];
            end

            eca_cell u_cell (
                .l    (w_left[gi]),
                .c    (r_data[gi]),
                .r    (w_right[gi]),
                .rule (r_rule),
                .next (w_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rule      <= '0;
            r_wrap      <= 1'b0;
            r_edge      <= 1'b0;
            r_data      <= '0;
            r_remaining <= '0;
            r_gen       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // abort has no meaning here, so a same-cycle config still lands
                    if (cfg_valid) begin
                        r_rule      <= cfg_rule;
                        r_wrap      <= cfg_wrap;
                        r_edge      <= cfg_edge;
                        r_data      <= cfg_seed;
                        r_remaining <= cfg_steps;
                        r_gen       <= '0;
                        r_state     <= EMIT;
                    end
                end
                EMIT: begin
                    // abort beats a same-cycle handshake: nothing advances, no done
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (out_ready) begin
                        if (r_remaining == '0) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_data      <= w_next;
                            r_remaining <= r_remaining - STEP_W'(1);
                            r_gen       <= r_gen + STEP_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_ready = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign busy      = (r_state == EMIT);
    assign out_data  = r_data;
    assign out_gen   = r_gen;
    assign done      = r_done;

endmodule

// File: tb/tb_eca_engine.sv
// tb/tb_eca_engine.sv - self-checking bench for eca_engine against a behavioural CA model
module tb_eca_engine;

    localparam int W  = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [7:0]    cfg_rule;
    logic [W-1:0]  cfg_seed;
    logic [SW-1:0] cfg_steps;
    logic          cfg_wrap;
    logic          cfg_edge;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_gen;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    eca_engine #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_rule  (cfg_rule),
        .cfg_seed  (cfg_seed),
        .cfg_steps (cfg_steps),
        .cfg_wrap  (cfg_wrap),
        .cfg_edge  (cfg_edge),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_gen   (out_gen),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each cell looks up rule bit (7 - neighbourhood value).
    function automatic logic [W-1:0] model_next(input logic [W-1:0] s, input logic [7:0] rule,
                                                input logic wrap, input logic edge_v);
        logic [W-1:0] n;
        int l, c, r, p;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) l = wrap ? int'(s[0]) : int'(edge_v);
            else            l = int'(s[i+1]);
            if (i == 0)     r = wrap ? int'(s[W-1]) : int'(edge_v);
            else            r = int'(s[i-1]);
            c = int'(s[i]);
            p = l * 4 + c * 2 + r;
            n[i] = rule[7-p];
        end
        return n;
    endfunction

    // mode 0: always ready; 1: random ready; 2: hold ready low 3 cycles at gen 1
    task automatic run_cfg(input logic [7:0] rule, input logic [W-1:0] seed, input logic [SW-1:0] steps,
                           input logic wrap, input logic edge_v, input int mode, input logic abort_in_cfg,
                           output logic [W-1:0] last, output int ntx);
        logic [W-1:0] m;
        int k, guard, stall;
        chk("cfg_ready_idle", cfg_ready, 1);
        cfg_valid = 1; cfg_rule = rule; cfg_seed = seed; cfg_steps = steps;
        cfg_wrap = wrap; cfg_edge = edge_v; abort = abort_in_cfg;
        @(negedge clk);
        abort = 0;
        m = seed; k = 0; ntx = 0; stall = 0; guard = 0; last = '0;
        while (k <= int'(steps) && guard < 2000) begin
            guard++;
            // junk config mid-run must be ignored
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_rule  = 8'($urandom); cfg_seed = W'($urandom);
            cfg_wrap  = 1'($urandom_range(0, 1)); cfg_edge = 1'($urandom_range(0, 1));
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && k == 1 && stall < 3) begin out_ready = 0; stall++; end
            else out_ready = 1;
            chk("out_valid_run", out_valid, 1);
            chk("busy_run", busy, 1);
            chk("cfg_ready_run", cfg_ready, 0);
            chk("done_run", done, 0);
            chk("out_data", out_data, m);
            chk("out_gen", out_gen, k);
            @(negedge clk);
            if (out_ready) begin
                last = m; ntx++; m = model_next(m, rule, wrap, edge_v); k++;
            end
        end
        if (guard >= 2000) chk("run_timeout", 0, 1);
        cfg_valid = 0;
        out_ready = 1'($urandom_range(0, 1));
        chk("done_pulse", done, 1);
        chk("out_valid_end", out_valid, 0);
        chk("busy_end", busy, 0);
        chk("cfg_ready_end", cfg_ready, 1);
        @(negedge clk);
        chk("done_clear", done, 0);
    endtask

    initial begin
        logic [W-1:0] last;
        int ntx;
        logic [W-1:0] m;

        rst = 1; cfg_valid = 0; cfg_rule = 0; cfg_seed = 0; cfg_steps = 0;
        cfg_wrap = 0; cfg_edge = 0; abort = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_gen", out_gen, 0);
        @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);

        // basic run: 10 -> 28 -> 44 under left XOR right
        run_cfg(8'h5A, 8'h10, 16'd2, 1, 0, 0, 0, last, ntx);
        chk("t1_last", last, 8'h44);
        chk("t1_ntx", ntx, 3);

        // boundary handling
        run_cfg(8'h5A, 8'h80, 16'd1, 1, 0, 0, 0, last, ntx);
        chk("t2_wrap", last, 8'h41);
        run_cfg(8'h5A, 8'h80, 16'd1, 0, 0, 0, 0, last, ntx);
        chk("t2_edge0", last, 8'h40);
        run_cfg(8'h5A, 8'h80, 16'd1, 0, 1, 0, 0, last, ntx);
        chk("t2_edge1", last, 8'hC1);
        run_cfg(8'h2D, 8'hFF, 16'd1, 0, 0, 0, 0, last, ntx);
        chk("t3_ff", last, 8'h7E);
        run_cfg(8'h2D, 8'h00, 16'd1, 0, 0, 0, 0, last, ntx);
        chk("t3_00", last, 8'h00);

        // backpressure and single-transfer run
        run_cfg(8'h96, 8'h35, 16'd3, 1, 0, 2, 0, last, ntx);
        chk("t4_ntx", ntx, 4);
        run_cfg(8'h1E, 8'hA7, 16'd0, 0, 1, 0, 0, last, ntx);
        chk("t4_single", ntx, 1);
        chk("t4_single_data", last, 8'hA7);

        // abort at gen 2, then an immediate new run (abort in IDLE is ignored)
        cfg_valid = 1; cfg_rule = 8'h5A; cfg_seed = 8'h10; cfg_steps = 16'd10;
        cfg_wrap = 1; cfg_edge = 0; out_ready = 1;
        @(negedge clk);
        cfg_valid = 0;
        m = 8'h10;
        for (int g = 0; g < 2; g++) begin
            chk("t5_gen", out_gen, g);
            @(negedge clk);
            m = model_next(m, 8'h5A, 1, 0);
        end
        chk("t5_gen2", out_gen, 2);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("t5_valid", out_valid, 0);
        chk("t5_done", done, 0);
        chk("t5_cfg_ready", cfg_ready, 1);
        chk("t5_hold_data", out_data, m);
        run_cfg(8'h6E, 8'h5C, 16'd4, 0, 1, 1, 1, last, ntx);
        chk("t5_new_ntx", ntx, 5);

        // randomized runs
        for (int t = 0; t < 20; t++) begin
            logic [SW-1:0] st;
            st = SW'($urandom_range(0, 12));
            run_cfg(8'($urandom), W'($urandom), st, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), last, ntx);
            chk("rand_ntx", ntx, int'(st) + 1);
        end

        // reset mid-run with a config offered
        cfg_valid = 1; cfg_rule = 8'h5A; cfg_seed = 8'h10; cfg_steps = 16'd5;
        cfg_wrap = 1; cfg_edge = 0; out_ready = 1;
        @(negedge clk);
        cfg_valid = 0;
        @(negedge clk);
        rst = 1; cfg_valid = 1; cfg_seed = 8'hAA;
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_data", out_data, 0);
        chk("t6_gen", out_gen, 0);
        rst = 0; cfg_valid = 0;
        @(negedge clk);
        chk("t6_cfg_ready", cfg_ready, 1);
        chk("t6_no_latch", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
